// File: rtl/ones_pkg.sv
// Shared types and default sizing for the ones-count window statistics block.
package ones_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } ones_state_e;

  localparam int DEF_CNT_W  = 5;
  localparam int DEF_WIN    = 8;
  localparam int DEF_THRESH = 8;

  function automatic int sum_width(input int cnt_w, input int win);
    return cnt_w + $clog2(win);
  endfunction

  function automatic int over_width(input int win);
    return $clog2(win) + 1;
  endfunction

  localparam int DEF_SUM_W  = sum_width(DEF_CNT_W, DEF_WIN);
  localparam int DEF_OVER_W = over_width(DEF_WIN);

endpackage

// File: rtl/ones_window_stats_skid_slot.sv
// One-entry holding slot for a count that arrives while a record is still waiting.
module ones_skid_slot #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic         valid_d,
  input  logic [W-1:0] data_d,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (we) begin
      valid <= valid_d;
      data  <= data_d;
    end
  end

endmodule

// File: rtl/ones_window_stats.sv
// Window statistics (sum/min/max/avg/over-threshold) over WIN ones counts.
// Optional skid slot for samples arriving in HOLD: define ONES_STATS_SKID_EN.
module ones_window_stats
  import ones_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WIN    = DEF_WIN,
  parameter int THRESH = DEF_THRESH,
  localparam int LOG_WIN = $clog2(WIN),
  localparam int SUM_W   = sum_width(CNT_W, WIN),
  localparam int OVER_W  = over_width(WIN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              cnt_valid,
  output logic              stat_valid,
  input  logic              stat_ready,
  output logic [SUM_W-1:0]  sum_out,
  output logic [CNT_W-1:0]  min_out,
  output logic [CNT_W-1:0]  max_out,
  output logic [CNT_W-1:0]  avg_out,
  output logic [OVER_W-1:0] over_cnt,
  output logic              busy,
  output logic              drop_err,
  output ones_state_e       state_dbg
);

  // Handshake: a record transfers on any rising edge where stat_valid && stat_ready;
  // stat_valid and all data outputs are held unchanged until that edge.
  ones_state_e state, state_n;

  logic [LOG_WIN-1:0] win_cnt;
  logic [SUM_W-1:0]   acc_sum, sum_n;
  logic [CNT_W-1:0]   acc_min, acc_max, min_n, max_n;
  logic [OVER_W-1:0]  acc_over, over_n;

  logic               handshake, take_ok, sample_v, last, drop;
  logic [CNT_W-1:0]   sample;
  logic               slot_valid;
  logic [CNT_W-1:0]   slot_data;

  assign handshake = stat_valid && stat_ready;
  assign take_ok   = (state != HOLD) || handshake;

`ifdef ONES_STATS_SKID_EN
  logic slot_we, slot_d_valid;

  // When samples can be taken, the slot drains and refills from any concurrent
  // pulse; in HOLD without handshake it only loads if empty.
  assign slot_we      = take_ok || (cnt_valid && !slot_valid);
  assign slot_d_valid = take_ok ? (slot_valid && cnt_valid) : 1'b1;
  assign drop         = cnt_valid && !take_ok && slot_valid;

  ones_skid_slot #(.W(CNT_W)) u_slot (
    .clk     (clk),
    .reset   (reset),
    .we      (slot_we),
    .valid_d (slot_d_valid),
    .data_d  (cnt_in),
    .valid   (slot_valid),
    .data    (slot_data)
  );
`else
  assign slot_valid = 1'b0;
  assign slot_data  = '0;
  assign drop       = cnt_valid && !take_ok;
`endif

  // The older slot entry goes first so arrival order is preserved.
  assign sample_v = take_ok && (slot_valid || cnt_valid);
  assign sample   = slot_valid ? slot_data : cnt_in;
  assign last     = (win_cnt == LOG_WIN'(WIN - 1));

  always_comb begin
    sum_n  = acc_sum + SUM_W'(sample);
    min_n  = (sample < acc_min) ? sample : acc_min;
    max_n  = (sample > acc_max) ? sample : acc_max;
    over_n = acc_over + ((32'(sample) >= 32'(THRESH)) ? OVER_W'(1) : OVER_W'(0));
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (sample_v) state_n = ACCUM;
      ACCUM:   if (sample_v && last) state_n = HOLD;
      HOLD:    if (handshake) state_n = sample_v ? ACCUM : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      drop_err   <= 1'b0;
      stat_valid <= 1'b0;
      win_cnt    <= '0;
      acc_sum    <= '0;
      acc_min    <= '1;
      acc_max    <= '0;
      acc_over   <= '0;
      sum_out    <= '0;
      min_out    <= '0;
      max_out    <= '0;
      avg_out    <= '0;
      over_cnt   <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      if (drop) drop_err <= 1'b1;
      if (handshake) stat_valid <= 1'b0;
      if (sample_v) begin
        if (last) begin
          sum_out    <= sum_n;
          min_out    <= min_n;
          max_out    <= max_n;
          avg_out    <= sum_n[SUM_W-1:LOG_WIN];
          over_cnt   <= over_n;
          stat_valid <= 1'b1;
          win_cnt    <= '0;
          acc_sum    <= '0;
          acc_min    <= '1;
          acc_max    <= '0;
          acc_over   <= '0;
        end else begin
          win_cnt    <= win_cnt + LOG_WIN'(1);
          acc_sum    <= sum_n;
          acc_min    <= min_n;
          acc_max    <= max_n;
          acc_over   <= over_n;
        end
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/ones_window_stats.md
# ones_window_stats

Downstream consumer of the bit-serial ones-counter.
- Captures each per-word ones count on the counter's one-cycle done pulse.
- Accumulates statistics over a fixed window of WIN words: sum, min, max, average, and count of words at or above a threshold.
- Presents one result record per window on a valid/ready output for the checker/logger stage.

## Interface
- CNT_W, 5: width of incoming ones count (0..16 for 16-bit words)
- WIN, 8: words per window; power of two, ≥2
- THRESH, 8: count ≥ THRESH increments over_cnt
- clk  in  1  rising-edge clock; one clock, no other domains
- reset  in  1  synchronous, active-high reset
- cnt_in  in  CNT_W  ones count of the finished word
- cnt_valid  in  1  one-cycle pulse; cnt_in valid this cycle
- stat_valid  out  1  result record valid
- stat_ready  in  1  consumer accepts record
- sum_out  out  CNT_W+$clog2(WIN)  window sum
- min_out  out  CNT_W  window minimum
- max_out  out  CNT_W  window maximum
- avg_out  out  CNT_W  sum_out >> $clog2(WIN), truncated
- over_cnt  out  $clog2(WIN)+1  words with cnt ≥ THRESH
- busy  out  1  state ≠ IDLE
- drop_err  out  1  sticky: a sample was discarded

## Operation
- FSM states:
  - IDLE: no samples in window.
  - ACCUM: 1..WIN-1 samples taken.
  - HOLD: record presented.
- Reset: state IDLE; all outputs 0; internal sample counter 0; running min = all-ones; running max/sum/over = 0.
- Sample acceptance: cnt_valid in IDLE/ACCUM is accepted.
  - sum += cnt_in; min/max updated; over += (cnt_in ≥ THRESH); counter++.
  - IDLE→ACCUM on the first sample.
- Window completion: on the WIN-th sample, the final values are registered to the outputs, stat_valid=1, and state→HOLD.
  - Accumulators clear at the same edge.
- HOLD:
  - Outputs stay stable until stat_valid && stat_ready.
  - At the handshake edge: stat_valid=0, state→IDLE. Data outputs keep their last values.
- Simultaneous events:
  - cnt_valid in the handshake cycle is accepted as sample 1 of the next window, and the state goes to ACCUM.
  - cnt_valid in HOLD without stat_ready is handled per Configuration.
- Widths:
  - The sum cannot overflow, by width choice.
  - cnt_in above 2^(CNT_W-1) is accepted unmodified; no clamping.
- Reset mid-window or in HOLD discards everything. drop_err clears only on reset.

## Timing
- Latency: stat_valid rises the cycle after the edge that captured the WIN-th sample.
- Min spacing between windows: WIN pulses. With back-to-back pulses, throughput is one sample per cycle.
- stat_valid never drops without a handshake. Outputs never change while stat_valid=1.
- busy is registered, equal to (state ≠ IDLE).

## Configuration
- ONES_STATS_SKID_EN defined: adds a one-entry skid slot.
  - A sample arriving in HOLD without handshake goes into the slot.
  - A second such sample is dropped and sets drop_err.
  - In IDLE/ACCUM with the slot full:
    - The slot entry is accumulated each cycle.
    - A concurrent cnt_valid refills the slot; otherwise the slot empties.
    - Arrival order is preserved.
  - At the handshake edge, the slot entry becomes sample 1, and any concurrent cnt_valid enters the slot.
- ONES_STATS_SKID_EN undefined: any cnt_valid in HOLD without handshake is discarded and drop_err=1.

## Structure
- Package ones_pkg:
  - State enum (IDLE, ACCUM, HOLD).
  - Default CNT_W/WIN/THRESH localparams.
  - Output width helper localparams.
- Sub-module ones_skid_slot: valid flag plus data register. Instantiated only under ONES_STATS_SKID_EN.
- Everything else is in ones_window_stats.

## Test plan
- Reset mid-window, then check recovery.
  - Stimulus: reset held 2 cycles after 2 samples, then a new 4-sample window.
  - Required: all outputs 0 and busy=0 after reset; the next window's stats exclude pre-reset samples.
- Basic window, WIN=4, THRESH=8.
  - Stimulus: pulses 3, 7, 0, 16; stat_ready=1.
  - Required: sum=26, min=0, max=16, avg=6, over_cnt=1; stat_valid high exactly 1 cycle, one cycle after the 4th pulse.
- Backpressure.
  - Stimulus: stat_ready=0 for 10 cycles after stat_valid, then 1.
  - Required: outputs stable throughout; the handshake drops stat_valid next cycle; state IDLE.
- Handshake-cycle sample.
  - Stimulus: pulse cnt_in=5 in the same cycle as stat_valid&&stat_ready, then 1, 1, 1.
  - Required: next record sum=8, min=1, max=5.
- Overrun, macro undefined.
  - Stimulus: pulse 9 in HOLD with stat_ready=0.
  - Required: drop_err=1 and stays 1; next window excludes 9.
- Overrun, ONES_STATS_SKID_EN defined.
  - Stimulus: pulse 9 in HOLD, then release.
  - Required: 9 is sample 1 of the next window; drop_err=0. A second HOLD pulse sets drop_err=1.
